reg_share_arb: RTL and testbench

REG_SHARE_ARB -- requirements
Module: reg_share_arb

---
 rtl/reg_share_arb_pkg.sv | 43 ++++
 rtl/reg_share_arb_register_en.sv | 34 +++
 rtl/reg_share_arb.sv | 175 +++++++++++++++++
 tb/tb_reg_share_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_share_arb_pkg.sv
// ---------------------------------------------------------------------------
// reg_share_arb_pkg
//   Shared constants for the two-requester register-sharing arbiter.
//   Imported by the arbiter RTL and by its testbench so that both sides agree
//   on the state encoding and on the default hold limit.
//
//   Contents:
//     state_t            - arbiter state encoding (IDLE / G0 / G1)
//     MAX_HOLD_DEFAULT   - default number of consecutive grant cycles before a
//                          waiting requester forces a hand-over
//     CNT_W              - width of the hold counter
//     sat_inc()          - saturating increment used by the hold counter
// ---------------------------------------------------------------------------
package reg_share_arb_pkg;

    // Arbiter states. The encoding is fixed so that gnt0/gnt1 line up with
    // bits 0/1 of the state when looking at waveforms.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    // Default hold limit; the legal range is 2..15 so that the limit minus one
    // always fits in the 4-bit hold counter.
    localparam int MAX_HOLD_DEFAULT = 4;

    // Hold counter width.
    localparam int CNT_W = 4;

    // Increment that sticks at the given limit instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic [CNT_W-1:0] limit);
        logic [CNT_W-1:0] result;
        if (value >= limit) begin
            result = value;
        end else begin
            result = value + 4'd1;
        end
        return result;
    endfunction

endpackage : reg_share_arb_pkg

// File: rtl/reg_share_arb_register_en.sv
// ---------------------------------------------------------------------------
// reg_share_arb_register_en
//   The shared data register: a bank of WIDTH enable D flip-flops with an
//   asynchronous active-low clear. When en is high the register captures d on
//   the rising clock edge, otherwise it keeps its contents.
//
//   Ports:
//     clk      in   1      rising-edge clock
//     reset_n  in   1      asynchronous active-low clear (q -> 0)
//     en       in   1      load enable
//     d        in   WIDTH  data to load
//     q        out  WIDTH  register contents
// ---------------------------------------------------------------------------
module reg_share_arb_register_en #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Enable flip-flop bank; the clear acts immediately, without a clock edge,
    // so a reset mid-grant discards any write that was about to happen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : reg_share_arb_register_en

// File: rtl/reg_share_arb.sv
// ---------------------------------------------------------------------------
// reg_share_arb
//   Arbitrates write access to one shared WIDTH-bit register between two
//   requesters. A grant is issued one cycle after a request is seen in IDLE.
//   Simultaneous requests from IDLE go to the requester that was not granted
//   most recently. A requester that keeps its request up may hold the
//   register for at most MAX_HOLD consecutive cycles while the other side is
//   waiting; if nobody else is waiting it may keep the grant indefinitely.
//   The granted requester writes its data on every edge where it still
//   requests; on a hand-over edge the write belongs to the outgoing side.
//
//   Ports:
//     clk      in   1      rising-edge clock
//     reset_n  in   1      asynchronous active-low reset
//     req0     in   1      requester 0 wants write access
//     req1     in   1      requester 1 wants write access
//     d0       in   WIDTH  write data from requester 0
//     d1       in   WIDTH  write data from requester 1
//     gnt0     out  1      registered grant to requester 0
//     gnt1     out  1      registered grant to requester 1
//     q        out  WIDTH  shared register contents
//     busy     out  1      a grant is active
//
//   Parameters:
//     WIDTH     data width (default 8)
//     MAX_HOLD  consecutive grant cycles before forced hand-over (2..15)
// ---------------------------------------------------------------------------
module reg_share_arb
    import reg_share_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    // Counter value at which the current owner has used up its hold budget.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    // Index of the requester granted most recently; starts at 1 so that
    // requester 0 wins the first tie after reset.
    logic             last;

    logic             reg_en;
    logic [WIDTH-1:0] reg_d;

    // Arbiter FSM. Grants and busy are registered alongside the state so that
    // they are glitch-free and change only on the clock edge (or on reset).
    // Every entry into a grant state clears the hold counter and records the
    // new owner in 'last'; staying in a grant state advances the counter,
    // which sticks at HOLD_LAST. Hand-over between owners goes directly from
    // G0 to G1 (or back) without passing through IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || last)) begin
                        state    <= G0;
                        hold_cnt <= '0;
                        last     <= 1'b0;
                        gnt0     <= 1'b1;
                        gnt1     <= 1'b0;
                        busy     <= 1'b1;
                    end else if (req1) begin
                        state    <= G1;
                        hold_cnt <= '0;
                        last     <= 1'b1;
                        gnt0     <= 1'b0;
                        gnt1     <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                        gnt0     <= 1'b0;
                        gnt1     <= 1'b0;
                        busy     <= 1'b0;
                    end
                end

                G0: begin
                    // Release by the owner, or forced hand-over once the hold
                    // budget is spent and requester 1 is waiting.
                    if ((!req0 && req1) || (req0 && req1 && hold_cnt == HOLD_LAST)) begin
                        state    <= G1;
                        hold_cnt <= '0;
                        last     <= 1'b1;
                        gnt0     <= 1'b0;
                        gnt1     <= 1'b1;
                        busy     <= 1'b1;
                    end else if (!req0) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                        gnt0     <= 1'b0;
                        gnt1     <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        state    <= G0;
                        hold_cnt <= sat_inc(hold_cnt, HOLD_LAST);
                        gnt0     <= 1'b1;
                        gnt1     <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                G1: begin
                    if ((!req1 && req0) || (req1 && req0 && hold_cnt == HOLD_LAST)) begin
                        state    <= G0;
                        hold_cnt <= '0;
                        last     <= 1'b0;
                        gnt0     <= 1'b1;
                        gnt1     <= 1'b0;
                        busy     <= 1'b1;
                    end else if (!req1) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                        gnt0     <= 1'b0;
                        gnt1     <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        state    <= G1;
                        hold_cnt <= sat_inc(hold_cnt, HOLD_LAST);
                        gnt0     <= 1'b0;
                        gnt1     <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                    gnt0     <= 1'b0;
                    gnt1     <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // The write is qualified by the grant held during the current cycle, so
    // on a hand-over edge the outgoing owner's data is the one captured and
    // the incoming owner only writes from the following edge on.
    always_comb begin
        reg_en = (gnt0 && req0) || (gnt1 && req1);
        reg_d  = gnt0 ? d0 : d1;
    end

    reg_share_arb_register_en #(
        .WIDTH(WIDTH)
    ) u_register (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (reg_en),
        .d      (reg_d),
        .q      (q)
    );

endmodule : reg_share_arb

// File: tb/tb_reg_share_arb.sv
// ---------------------------------------------------------------------------
// tb_reg_share_arb
//   Self-checking bench for reg_share_arb. The stimulus process drives inputs
//   on the falling edge and pushes the expected post-edge outputs, computed by
//   an owner/hold-count reference model, into a queue. A monitor pops one
//   entry after every rising edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_reg_share_arb;
    import reg_share_arb_pkg::*;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = MAX_HOLD_DEFAULT;

    logic             clk;
    logic             reset_n;
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] q;
    logic             busy;

    typedef struct {
        logic             g0;
        logic             g1;
        logic             busy;
        logic [WIDTH-1:0] q;
    } exp_t;

    exp_t exp_q[$];

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: who owns the register (-1 = nobody), how many
    // consecutive cycles it has owned it, and who was granted most recently.
    int               m_owner;
    int               m_hold;
    int               m_last;
    logic [WIDTH-1:0] m_q;

    reg_share_arb #(
        .WIDTH   (WIDTH),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .req0   (req0),
        .req1   (req1),
        .d0     (d0),
        .d1     (d1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .q      (q),
        .busy   (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_owner = -1;
        m_hold  = 0;
        m_last  = 1;
        m_q     = '0;
    endtask

    // One rising edge of the model: the current owner writes if it still
    // requests, then ownership is decided from the request pattern.
    task automatic modelStep(input logic r0, input logic r1,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic             r[2];
        logic [WIDTH-1:0] dd[2];
        int               nxt;
        int               other;
        r[0] = r0; r[1] = r1;
        dd[0] = a; dd[1] = b;

        if (m_owner >= 0 && r[m_owner]) m_q = dd[m_owner];

        if (m_owner < 0) begin
            if (r0 && r1)  nxt = 1 - m_last;
            else if (r0)   nxt = 0;
            else if (r1)   nxt = 1;
            else           nxt = -1;
        end else begin
            other = 1 - m_owner;
            if (!r[m_owner])                        nxt = r[other] ? other : -1;
            else if (m_hold >= MAX_HOLD && r[other]) nxt = other;
            else                                    nxt = m_owner;
        end

        if (nxt < 0) begin
            m_hold = 0;
        end else if (nxt != m_owner) begin
            m_hold = 1;
            m_last = nxt;
        end else begin
            m_hold++;
        end
        m_owner = nxt;
    endtask

    // Drive one cycle of inputs on the falling edge and queue the outputs the
    // DUT should show after the following rising edge.
    task automatic applyStimulus(input logic rst, input logic r0, input logic r1,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        @(negedge clk);
        reset_n = rst;
        req0    = r0;
        req1    = r1;
        d0      = a;
        d1      = b;
        if (!rst) modelReset();
        else      modelStep(r0, r1, a, b);
        e.g0   = (m_owner == 0);
        e.g1   = (m_owner == 1);
        e.busy = (m_owner >= 0);
        e.q    = m_q;
        exp_q.push_back(e);
    endtask

    // Pulse reset low between edges and confirm the outputs clear without any
    // clock edge; the release happens on the next falling edge.
    task automatic asyncResetPulse();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_gnt0", 32'(gnt0), 32'd0);
        checkOutput("async_rst_gnt1", 32'(gnt1), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_q", 32'(q), 32'd0);
        modelReset();
    endtask

    // Monitor: the DUT presents a new output set after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("gnt0", 32'(gnt0), 32'(e.g0));
                checkOutput("gnt1", 32'(gnt1), 32'(e.g1));
                checkOutput("busy", 32'(busy), 32'(e.busy));
                checkOutput("q", 32'(q), 32'(e.q));
                checkOutput("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
            end
        end
    end

    initial begin
        logic             r0;
        logic             r1;
        logic             rst;
        reset_n = 1'b0;
        req0    = 1'b0;
        req1    = 1'b0;
        d0      = '0;
        d1      = '0;
        modelReset();

        #1;
        checkOutput("reset_gnt0", 32'(gnt0), 32'd0);
        checkOutput("reset_gnt1", 32'(gnt1), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_q", 32'(q), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Single requester 0 writing A5.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'hA5, 8'h5A);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

        // Fresh reset, then both requesting: 0 first, alternating every
        // MAX_HOLD cycles.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 3 * MAX_HOLD + 2; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, 8'(8'h10 + i), 8'(8'h80 + i));
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

        // Requester 1 owns, then drops while 0 waits.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 8'hC7);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 8'hD8);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h44, 8'hEE);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h45, 8'hEF);

        // Requester 0 holds alone for a long stretch.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h3C, 8'h99);
        // Requester 1 joins after saturation: immediate hand-over.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h3D, 8'h9A);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h3E, 8'h9B);

        // Asynchronous reset in the middle of a grant.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h77, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h78, 8'h00);
        asyncResetPulse();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h61, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h62, 8'h00);

        // Withdraw with the other side idle: back to IDLE, q unchanged.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hFE, 8'hFE);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            r0  = ($urandom_range(0, 3) != 0);
            r1  = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 63) != 0);
            applyStimulus(rst, r0, r1, 8'($urandom), 8'($urandom));
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        #2;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_reg_share_arb
